quad_decoder: RTL

Quadrature (A/B) incremental-encoder decoder that produces the up/down position count. It is the input-side partner of the team's up/down counter: it derives the direction and step events from the physical encoder lines and keeps the count itself. The decoder uses x4 decoding, so every legal A/B edge is one count. It sits between the board-level encoder pins and the display/control logic.

---
 rtl/quad_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// Quadrature (A/B) x4 decoder with glitch filter and position counter.
// Optional index channel (z_in / idx) is compiled in when INDEX_EN is defined.
// Filtered channel state is held as {B,A}: A leading B counts up,
// i.e. 00 -> 01 -> 11 -> 10 -> 00 is the up direction.

// Per-channel-group conditioner: 2-FF synchronizer plus hold-for-FILT filter.
module qd_filt #(
  parameter int W    = 1,
  parameter int FILT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] state,
  output logic [W-1:0] nxt,
  output logic         acc
);
  logic [W-1:0] s1, s2, cand;
  logic [3:0]   cnt, cnt_nx;

  // Two-stage synchronizer; reset clears it so the first filtered state is 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
    end
  end

  // Count consecutive edges on which a stable value differs from state;
  // a change of value restarts at 1, a return to state clears the count.
  always_comb begin
    cnt_nx = 4'd0;
    if (s2 == state)     cnt_nx = 4'd0;
    else if (s2 != cand) cnt_nx = 4'd1;
    else                 cnt_nx = cnt + 4'd1;
  end

  assign acc = (s2 != state) && (cnt_nx == 4'(FILT));
  assign nxt = s2;

  // Filter state: cand remembers the previous sample to detect changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand  <= '0;
      cnt   <= 4'd0;
      state <= '0;
    end else begin
      cand <= s2;
      if (acc) begin
        state <= s2;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt_nx;
      end
    end
  end
endmodule

module quad_decoder #(
  parameter int WIDTH = 8,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
`ifdef INDEX_EN
  ,
  input  logic             z_in,
  output logic             idx
`endif
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0] ab_q, ab_nx, delta;
  logic       ab_acc, up, dn, bad, z_hit;

  // Gray code to quadrant position: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gpos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  qd_filt #(.W(2), .FILT(FILT)) u_ab (
    .clk   (clk),
    .rst   (rst),
    .d_in  ({b_in, a_in}),
    .state (ab_q),
    .nxt   (ab_nx),
    .acc   (ab_acc)
  );

  // Position difference of an accepted transition: +1 up, -1 down, 2 illegal.
  always_comb begin
    delta = gpos(ab_nx) - gpos(ab_q);
    up    = ab_acc && (delta == 2'd1);
    dn    = ab_acc && (delta == 2'd3);
    bad   = ab_acc && (delta == 2'd2);
  end

`ifdef INDEX_EN
  logic z_q, z_nx, z_acc;

  qd_filt #(.W(1), .FILT(FILT)) u_z (
    .clk   (clk),
    .rst   (rst),
    .d_in  (z_in),
    .state (z_q),
    .nxt   (z_nx),
    .acc   (z_acc)
  );

  // Only a rising index edge re-zeroes the count.
  assign z_hit = z_acc && z_nx && !z_q;

  // One-cycle index pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idx <= 1'b0;
    else      idx <= z_hit;
  end
`else
  assign z_hit = 1'b0;
`endif

  // Count/dir/step/err update; clear and index beat a same-edge step on
  // count only, step and dir still report the movement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      dir   <= 1'b1;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      step <= up | dn;
      if (up | dn) dir <= up;
      if (clr || z_hit) count <= '0;
      else if (up)      count <= count + ONE;
      else if (dn)      count <= count - ONE;
      if (clr)      err <= 1'b0;
      else if (bad) err <= 1'b1;
    end
  end
endmodule
